aes_key_expander: RTL and testbench

Iterative AES key-schedule generator that feeds the subkey store. When the core receives a new cipher key, this block clears the store's valid bits and then writes one 128-bit round key per cycle, addresses 0 upward. The AXI4-Lite front end drives it with a one-cycle `start`. The encrypt and decrypt datapaths read the resulting round keys from the store.

---
 rtl/aes_key_expander.sv | 196 +++++++++++++++++++
 tb/tb_aes_key_expander.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: clears the subkey store, then writes one round key per cycle.
// Optional AES-256 support is compiled in with `define KEYEXP_AES256_EN.
module aes_key_expander #(
    parameter int NR128 = 10,
    parameter int NR256 = 14
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         reset_valid_bits,
    output logic         w_en,
    output logic [3:0]   waddr,
    output logic [127:0] wkey
);

    typedef enum logic [1:0] {IDLE, CLR, GEN, DONE} state_t;

    // NOTE: a constant table needs no reset; it synthesizes to ROM/LUT logic, not flops.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Chained-XOR step shared by both key lengths; rot selects the rotate+rcon variant.
    function automatic logic [127:0] next_key(input logic [127:0] base, input logic [31:0] w3,
                                              input logic rot, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = rot ? (sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0}) : sub_word(w3);
        n0 = base[127:96] ^ t;
        n1 = base[95:64]  ^ n0;
        n2 = base[63:32]  ^ n1;
        n3 = base[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     r_q, r_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [127:0]   cur_q, cur_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rvb_q, rvb_d;
    logic           w_en_q, w_en_d;
    logic [3:0]     waddr_q, waddr_d;
    logic [127:0]   wkey_q, wkey_d;

    logic           aes256;
    logic           rot_mode;
    logic [31:0]    w3_src;
    logic [127:0]   gen_key;
    logic [3:0]     last_addr;
    logic           write;

`ifdef KEYEXP_AES256_EN
    // nxt_q holds round key r+1 so key r+2 can be built from keys r and r+1.
    logic           len_q, len_d;
    logic [127:0]   nxt_q, nxt_d;
    assign aes256 = len_q;
    assign w3_src = aes256 ? nxt_q[31:0] : cur_q[31:0];
`else
    logic unused_inputs;
    assign unused_inputs = ^{key_len, key_in[127:0], 4'(NR256)};
    assign aes256 = 1'b0;
    assign w3_src = cur_q[31:0];
`endif

    assign rot_mode  = aes256 ? ~r_q[0] : 1'b1;
    assign gen_key   = next_key(cur_q, w3_src, rot_mode, rcon_q);
    assign last_addr = aes256 ? 4'(NR256) : 4'(NR128);

    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        rcon_d  = rcon_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rvb_d   = 1'b0;
        w_en_d  = 1'b0;
        waddr_d = waddr_q;
        wkey_d  = wkey_q;
        write   = 1'b0;
`ifdef KEYEXP_AES256_EN
        len_d   = len_q;
        nxt_d   = nxt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = CLR;
                    busy_d  = 1'b1;
                    rvb_d   = 1'b1;
                    r_d     = 4'd0;
                    rcon_d  = 8'h01;
                    cur_d   = key_in[255:128];
`ifdef KEYEXP_AES256_EN
                    nxt_d   = key_in[127:0];
                    len_d   = key_len;
`endif
                end
            end
            CLR: begin
                state_d = GEN;
                write   = 1'b1;
            end
            GEN: begin
                if (waddr_q == last_addr) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    write = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Present key r on the store port while computing the next key behind it.
        if (write) begin
            w_en_d  = 1'b1;
            waddr_d = r_q;
            wkey_d  = cur_q;
            r_d     = r_q + 4'd1;
            cur_d   = gen_key;
            if (rot_mode) rcon_d = xtime(rcon_q);
`ifdef KEYEXP_AES256_EN
            if (aes256) cur_d = nxt_q;
            nxt_d = gen_key;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            rcon_q  <= 8'h01;
            cur_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rvb_q   <= 1'b0;
            w_en_q  <= 1'b0;
            waddr_q <= 4'd0;
            wkey_q  <= '0;
`ifdef KEYEXP_AES256_EN
            len_q   <= 1'b0;
            nxt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            rcon_q  <= rcon_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rvb_q   <= rvb_d;
            w_en_q  <= w_en_d;
            waddr_q <= waddr_d;
            wkey_q  <= wkey_d;
`ifdef KEYEXP_AES256_EN
            len_q   <= len_d;
            nxt_q   <= nxt_d;
`endif
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign reset_valid_bits = rvb_q;
    assign w_en             = w_en_q;
    assign waddr            = waddr_q;
    assign wkey             = wkey_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: scoreboard of round keys from an independent
// word-oriented key-schedule model with an S-box derived from GF(2^8) inversion.
module tb_aes_key_expander;

    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] F128_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] F128_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] F256_2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] F256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         key_len;
    logic [255:0] key_in;
    logic         busy, done, reset_valid_bits, w_en;
    logic [3:0]   waddr;
    logic [127:0] wkey;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] key;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] cap[16];
    logic [7:0]   sbox_m[256];
    int           n_tests = 0;
    int           n_fail  = 0;

    aes_key_expander dut (
        .clk              (clk),
        .resetn           (resetn),
        .start            (start),
        .key_len          (key_len),
        .key_in           (key_in),
        .busy             (busy),
        .done             (done),
        .reset_valid_bits (reset_valid_bits),
        .w_en             (w_en),
        .waddr            (waddr),
        .wkey             (wkey)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // FIPS-197 KeyExpansion over 32-bit words; pushes every round key to the scoreboard.
    task automatic push_expected(input logic [255:0] k, input bit is256);
        logic [31:0] w[60];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        exp_t        e;
        int          nk = is256 ? 8 : 4;
        int          nr = is256 ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_w({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                temp = sub_w(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int j = 0; j <= nr; j++) begin
            e.addr = 4'(j);
            e.key  = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
            sb.push_back(e);
        end
    endtask

    // Advance to the next falling edge and retire one scoreboard entry per store write.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (w_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 128'(w_en), 128'd0);
            end else begin
                e = sb.pop_front();
                check("waddr", 128'(waddr), 128'(e.addr));
                check("wkey", wkey, e.key);
                cap[waddr] = wkey;
            end
        end
    endtask

    task automatic issue_start(input logic [255:0] k, input logic len, input bit is256);
        push_expected(k, is256);
        start   = 1'b1;
        key_in  = k;
        key_len = len;
        tick();
        start   = 1'b0;
        key_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Called in cycle 1 after the start edge; returns in the DONE cycle.
    task automatic follow_seq(input int nw, input int poke_c);
        check("rvb_cycle1", 128'(reset_valid_bits), 128'd1);
        check("w_en_cycle1", 128'(w_en), 128'd0);
        check("busy_cycle1", 128'(busy), 128'd1);
        for (int c = 2; c <= nw + 1; c++) begin
            if (c == poke_c) begin
                start   = 1'b1;
                key_in  = ~key_in;
                key_len = ~key_len;
            end
            tick();
            start = 1'b0;
            check("w_en_gen", 128'(w_en), 128'd1);
        end
        tick();
        check("done_pulse", 128'(done), 128'd1);
        check("busy_done", 128'(busy), 128'd0);
        check("w_en_done", 128'(w_en), 128'd0);
        check("sb_drained", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        build_sbox();
        resetn  = 1'b0;
        start   = 1'b0;
        key_len = 1'b0;
        key_in  = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_rvb", 128'(reset_valid_bits), 128'd0);
        check("rst_w_en", 128'(w_en), 128'd0);
        check("rst_waddr", 128'(waddr), 128'd0);
        check("rst_wkey", wkey, 128'd0);
        resetn = 1'b1;
        repeat (5) tick();
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_w_en", 128'(w_en), 128'd0);

        // FIPS-197 AES-128 vector
        issue_start({K128, 128'h0}, 1'b0, 1'b0);
        follow_seq(11, 0);
        check("fips128_k1", cap[1], F128_1);
        check("fips128_k10", cap[10], F128_10);
        tick();
        check("idle_after_done", 128'(busy), 128'd0);

        // start during GEN is ignored; start in the DONE cycle restarts at once
        issue_start({$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0, 1'b0);
        follow_seq(11, 6);
        issue_start({K128, 128'h0}, 1'b0, 1'b0);
        follow_seq(11, 0);
        check("chain_k10", cap[10], F128_10);
        tick();

        // asynchronous reset in the middle of GEN, then a clean rerun
        issue_start({K128, 128'h0}, 1'b0, 1'b0);
        repeat (6) tick();
        #2 resetn = 1'b0;
        #1;
        check("midrst_w_en", 128'(w_en), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_wkey", wkey, 128'd0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        issue_start({K128, 128'h0}, 1'b0, 1'b0);
        follow_seq(11, 0);
        check("rerun_k1", cap[1], F128_1);
        tick();

`ifdef KEYEXP_AES256_EN
        issue_start(K256, 1'b1, 1'b1);
        follow_seq(15, 0);
        check("aes256_k2", cap[2], F256_2);
        check("aes256_k14", cap[14], F256_14);
        tick();
        issue_start({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    1'b1, 1'b1);
        follow_seq(15, 0);
        tick();
`else
        issue_start({K128, 128'hffeeddccbbaa99887766554433221100}, 1'b1, 1'b0);
        follow_seq(11, 0);
        check("len1_ignored_k10", cap[10], F128_10);
        tick();
`endif
        issue_start({$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0, 1'b0);
        follow_seq(11, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
